// File: rtl/rs_codec_scheduler_pkg.sv
// Shared types and helpers for the RS(15,9) GF(16) codec scheduler.
package rs_pkg;

  localparam int unsigned SYM_W = 4;
  localparam int unsigned N     = 15;
  localparam int unsigned K     = 9;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_ENC_START,
    ST_ENC_WAIT,
    ST_INJECT,
    ST_DEC_START,
    ST_DEC_WAIT,
    ST_DONE
  } state_e;

  // Number of nonzero symbols in a codeword-wide word.
  function automatic logic [3:0] count_nz_symbols(input logic [N*SYM_W-1:0] w);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w[i*SYM_W +: SYM_W] != '0) c = c + 4'd1;
    end
    return c;
  endfunction

endpackage

// File: rtl/rs_codec_scheduler_phase_timer.sv
// Settle + timeout counter shared by the encode and decode phases.
// start_i loads the settle count; while run_i is high the settle count
// drains first, then each busy cycle advances the timeout count.
module rs_phase_timer
  import rs_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic run_i,
  input  logic busy_i,
  output logic done_o,
  output logic timeout_o
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] settle_q, settle_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       post_settle;

  assign post_settle = run_i && (settle_q == '0);
  assign done_o      = post_settle && !busy_i;
  assign timeout_o   = post_settle && busy_i && (tcnt_q == TMO_LAST);

  // Next-state for the settle and timeout counters.
  always_comb begin
    settle_d = settle_q;
    tcnt_d   = tcnt_q;
    if (start_i) begin
      settle_d = SETTLE_LD;
      tcnt_d   = '0;
    end else if (run_i) begin
      if (settle_q != '0) settle_d = settle_q - 8'd1;
      else if (busy_i)    tcnt_d   = tcnt_q + 8'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q <= '0;
      tcnt_q   <= '0;
    end else begin
      settle_q <= settle_d;
      tcnt_q   <= tcnt_d;
    end
  end

endmodule

// File: rtl/rs_codec_scheduler.sv
// Transaction sequencer for the RS(15,9) encoder/decoder pair: accepts a
// message plus channel error mask, encodes, injects errors, decodes and
// presents the result with match and diagnostic flags.
module rs_codec_scheduler
  import rs_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned T_CORRECT      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [35:0] in_message,
  input  logic [59:0] in_error,
  output logic [35:0] enc_message,
  output logic        enc_toggle,
  input  logic        enc_busy,
  input  logic [59:0] enc_codeword,
  output logic [59:0] dec_word,
  output logic        dec_toggle,
  input  logic        dec_busy,
  input  logic [35:0] dec_message,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [35:0] out_message,
  output logic [59:0] out_codeword,
  output logic [3:0]  out_err_symbols,
  output logic        out_match,
  output logic        out_beyond_t,
  output logic        out_timeout
);

  localparam logic [3:0] T_LIM = 4'(T_CORRECT);

  state_e      state_q;
  logic        in_ready_q;
  logic [35:0] msg_q;
  logic [59:0] err_q;
  logic [35:0] enc_message_q;
  logic        enc_toggle_q;
  logic [59:0] dec_word_q;
  logic        dec_toggle_q;
  logic        out_valid_q;
  logic [35:0] out_message_q;
  logic [59:0] out_codeword_q;
  logic [3:0]  err_sym_q;
  logic        match_q;
  logic        beyond_q;
  logic        timeout_q;

  logic tmr_start, tmr_run, tmr_busy, tmr_done, tmr_timeout;

  assign tmr_start = (state_q == ST_ENC_START) || (state_q == ST_DEC_START);
  assign tmr_run   = (state_q == ST_ENC_WAIT)  || (state_q == ST_DEC_WAIT);
  assign tmr_busy  = (state_q == ST_DEC_WAIT) ? dec_busy : enc_busy;

  rs_phase_timer #(
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start_i   (tmr_start),
    .run_i     (tmr_run),
    .busy_i    (tmr_busy),
    .done_o    (tmr_done),
    .timeout_o (tmr_timeout)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_DRAIN;
      in_ready_q     <= 1'b0;
      msg_q          <= '0;
      err_q          <= '0;
      enc_message_q  <= '0;
      enc_toggle_q   <= 1'b0;
      dec_word_q     <= '0;
      dec_toggle_q   <= 1'b0;
      out_valid_q    <= 1'b0;
      out_message_q  <= '0;
      out_codeword_q <= '0;
      err_sym_q      <= '0;
      match_q        <= 1'b0;
      beyond_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_DRAIN: begin
          if (!enc_busy && !dec_busy) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            msg_q         <= in_message;
            err_q         <= in_error;
            enc_message_q <= in_message;
            match_q       <= 1'b0;
            beyond_q      <= 1'b0;
            timeout_q     <= 1'b0;
            err_sym_q     <= count_nz_symbols(in_error);
            in_ready_q    <= 1'b0;
            state_q       <= ST_ENC_START;
          end
        end
        ST_ENC_START: begin
          enc_toggle_q <= ~enc_toggle_q;
          state_q      <= ST_ENC_WAIT;
        end
        ST_ENC_WAIT: begin
          if (tmr_done) begin
            out_codeword_q <= enc_codeword;
            state_q        <= ST_INJECT;
          end else if (tmr_timeout) begin
            timeout_q   <= 1'b1;
            match_q     <= 1'b0;
            beyond_q    <= (err_sym_q > T_LIM);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_INJECT: begin
          dec_word_q <= out_codeword_q ^ err_q;
          state_q    <= ST_DEC_START;
        end
        ST_DEC_START: begin
          dec_toggle_q <= ~dec_toggle_q;
          state_q      <= ST_DEC_WAIT;
        end
        ST_DEC_WAIT: begin
          if (tmr_done) begin
            out_message_q <= dec_message;
            match_q       <= (dec_message == msg_q);
            beyond_q      <= (err_sym_q > T_LIM);
            out_valid_q   <= 1'b1;
            state_q       <= ST_DONE;
          end else if (tmr_timeout) begin
            timeout_q   <= 1'b1;
            match_q     <= 1'b0;
            beyond_q    <= (err_sym_q > T_LIM);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_DRAIN;
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign enc_message     = enc_message_q;
  assign enc_toggle      = enc_toggle_q;
  assign dec_word        = dec_word_q;
  assign dec_toggle      = dec_toggle_q;
  assign out_valid       = out_valid_q;
  assign out_message     = out_message_q;
  assign out_codeword    = out_codeword_q;
  assign out_err_symbols = err_sym_q;
  assign out_match       = match_q;
  assign out_beyond_t    = beyond_q;
  assign out_timeout     = timeout_q;

endmodule
